// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// The producer and consumer drive the master side, and the ALU drives the slave side.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             In_Valid;
  logic             In_Ready;
  logic [2:0]       Op;
  logic [WIDTH-1:0] Data1;
  logic [WIDTH-1:0] Data2;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Result_Hi;
  logic             Carry;
  logic             Zero;
  logic             Error;

  modport master (
    output In_Valid, Op, Data1, Data2, Out_Ready,
    input  In_Ready, Out_Valid, Result, Result_Hi, Carry, Zero, Error
  );

  modport slave (
    input  In_Valid, Op, Data1, Data2, Out_Ready,
    output In_Ready, Out_Valid, Result, Result_Hi, Carry, Zero, Error
  );
endinterface

// File: rtl/alu_seq.sv
// N-bit sequential ALU: logic and arithmetic ops take 1 cycle; with ALU_MUL_EN, MUL is shift-add (WIDTH+1 cycles).
// The result holds while Out_Ready is low, and a new op is accepted in the same cycle the old result drains.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     Clk,
  input  logic     Clear,
  alu_seq_if.slave bus
);
  localparam logic [2:0]       OP_ADD = 3'b000;
  localparam logic [2:0]       OP_SUB = 3'b001;
  localparam logic [2:0]       OP_AND = 3'b010;
  localparam logic [2:0]       OP_OR  = 3'b011;
  localparam logic [2:0]       OP_XOR = 3'b100;
  localparam logic [2:0]       OP_SHL = 3'b101;
  localparam logic [2:0]       OP_SHR = 3'b110;
  localparam logic [2:0]       OP_MUL = 3'b111;
  localparam logic [WIDTH-1:0] W_AMT  = WIDTH'(WIDTH);

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic             carry_q, zero_q, error_q;
  logic [WIDTH-1:0] a, b;
  logic             in_xfer, out_xfer;
  logic [WIDTH-1:0] res_d;
  logic             carry_d, err_d;
  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;

  assign a             = bus.Data1;
  assign b             = bus.Data2;
  assign bus.Out_Valid = (state_q == S_DONE);
  assign bus.In_Ready  = !Clear && ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.Out_Ready));
  assign in_xfer       = bus.In_Valid && bus.In_Ready;
  assign out_xfer      = bus.Out_Valid && bus.Out_Ready;
  assign bus.Result    = result_q;
  assign bus.Result_Hi = result_hi_q;
  assign bus.Carry     = carry_q;
  assign bus.Zero      = zero_q;
  assign bus.Error     = error_q;

  // The extra top/bottom bit of each shift result captures the last bit shifted out.
  always_comb begin
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} - {1'b0, b};
    shl_w   = {1'b0, a} << b;
    shr_w   = {a, 1'b0} >> b;
    res_d   = '0;
    carry_d = 1'b0;
    err_d   = 1'b0;
    case (bus.Op)
      OP_ADD: {carry_d, res_d} = add_w;
      OP_SUB: {carry_d, res_d} = sub_w;
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_XOR: res_d = a ^ b;
      OP_SHL: if (b < W_AMT) {carry_d, res_d} = shl_w;
      OP_SHR: if (b < W_AMT) begin
        res_d   = shr_w[WIDTH:1];
        carry_d = shr_w[0];
      end
      OP_MUL: begin
`ifndef ALU_MUL_EN
        err_d = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, prod_hi_q, prod_lo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] prod_hi_d, prod_lo_d;

  // {prod_hi, prod_lo} starts as {0, multiplier} and shifts right one step per cycle.
  always_comb begin
    step_sum  = {1'b0, prod_hi_q} + (prod_lo_q[0] ? {1'b0, mcand_q} : '0);
    prod_hi_d = step_sum[WIDTH:1];
    prod_lo_d = {step_sum[0], prod_lo_q[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q     <= '0;
      prod_hi_q   <= '0;
      prod_lo_q   <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (in_xfer) begin
`ifdef ALU_MUL_EN
            if (bus.Op == OP_MUL) begin
              mcand_q   <= a;
              prod_hi_q <= '0;
              prod_lo_q <= b;
              cnt_q     <= '0;
              state_q   <= S_BUSY;
            end else
`endif
            begin
              result_q    <= res_d;
              result_hi_q <= '0;
              carry_q     <= carry_d;
              zero_q      <= (res_d == '0);
              error_q     <= err_d;
              state_q     <= S_DONE;
            end
          end else if (out_xfer) begin
            state_q <= S_IDLE;
          end
        end
`ifdef ALU_MUL_EN
        S_BUSY: begin
          prod_hi_q <= prod_hi_d;
          prod_lo_q <= prod_lo_d;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_q    <= prod_lo_d;
            result_hi_q <= prod_hi_d;
            carry_q     <= 1'b0;
            zero_q      <= ({prod_hi_d, prod_lo_d} == '0);
            error_q     <= 1'b0;
            state_q     <= S_DONE;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
